// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-through data cache:
// FSM encoding, base address, address field layout and decode helpers.
package cache_pkg;

  localparam int unsigned BASE_ADDR    = 1024;
  localparam int          SET_BITS     = 6;
  localparam int          TAG_BITS     = 10;
  localparam int          NUM_SETS     = 1 << SET_BITS;
  localparam int          WORD_SEL_POS = 2;
  localparam int          INDEX_LSB    = WORD_SEL_POS + 1;
  localparam int          TAG_LSB      = INDEX_LSB + SET_BITS;
  localparam int          EFF_MSB      = TAG_LSB + TAG_BITS - 1;
  localparam int          EFF_W        = EFF_MSB - WORD_SEL_POS + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [SET_BITS-1:0] index;
    logic                word_sel;
  } addr_fields_t;

  // Only eff[EFF_MSB:2] feeds the decode, so the subtraction is done at that width.
  function automatic addr_fields_t decode_addr(input logic [31:0] addr);
    logic [EFF_MSB:WORD_SEL_POS] eff;
    eff = addr[EFF_MSB:WORD_SEL_POS] - EFF_W'(BASE_ADDR >> WORD_SEL_POS);
    decode_addr.tag      = eff[EFF_MSB:TAG_LSB];
    decode_addr.index    = eff[TAG_LSB-1:INDEX_LSB];
    decode_addr.word_sel = eff[WORD_SEL_POS];
  endfunction

  function automatic logic [31:0] select_word(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid/tag/line storage with combinational read by index,
// synchronous full-line fill or single-word update, and valid clear on rst.
module cache_way_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] i_index,
  output logic                o_valid,
  output logic [TAG_BITS-1:0] o_tag,
  output logic [63:0]         o_line,
  input  logic                i_fill_en,
  input  logic [TAG_BITS-1:0] i_fill_tag,
  input  logic [63:0]         i_fill_line,
  input  logic                i_word_we,
  input  logic                i_word_sel,
  input  logic [31:0]         i_word_data
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_BITS-1:0] r_tag  [NUM_SETS];
  logic [63:0]         r_data [NUM_SETS];

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_line  = r_data[i_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid bits alone decide whether an entry counts,
  // which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_line;
    end else if (i_word_we) begin
      if (i_word_sel) r_data[i_index][63:32] <= i_word_data;
      else            r_data[i_index][31:0]  <= i_word_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of the SRAM controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t              r_state;
  logic                r_sram_r_en;
  logic                r_sram_w_en;
  logic [NUM_SETS-1:0] r_lru;

  addr_fields_t        w_fields;
  logic [1:0]          w_valid;
  logic [TAG_BITS-1:0] w_tag  [2];
  logic [63:0]         w_line [2];
  logic [1:0]          w_hit_vec;
  logic [1:0]          w_fill_en;
  logic [1:0]          w_word_we;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_rd_hit;
  logic                w_rd_done;
  logic                w_wr_done;

  assign w_fields        = decode_addr(address);
  assign sram_address    = address;
  assign sram_write_data = write_data;
  assign sram_r_en       = r_sram_r_en;
  assign sram_w_en       = r_sram_w_en;

  // Inputs are held stable while ready=0, so the live address also indexes fills and write updates.
  for (genvar g = 0; g < 2; g++) begin : g_way
    assign w_hit_vec[g] = w_valid[g] && (w_tag[g] == w_fields.tag);
    assign w_fill_en[g] = w_rd_done && !rst && (r_lru[w_fields.index] == 1'(g));
    assign w_word_we[g] = w_wr_done && !rst && w_hit_vec[g];

    cache_way_array u_way (
      .clk         (clk),
      .rst         (rst),
      .i_index     (w_fields.index),
      .o_valid     (w_valid[g]),
      .o_tag       (w_tag[g]),
      .o_line      (w_line[g]),
      .i_fill_en   (w_fill_en[g]),
      .i_fill_tag  (w_fields.tag),
      .i_fill_line (sram_read_data),
      .i_word_we   (w_word_we[g]),
      .i_word_sel  (w_fields.word_sel),
      .i_word_data (write_data)
    );
  end

  assign w_hit     = |w_hit_vec;
  assign w_hit_way = w_hit_vec[1];
  assign w_rd_hit  = (r_state == IDLE) && !mem_w_en && mem_r_en && w_hit;
  assign w_rd_done = (r_state == RD_MISS) && sram_ready;
  assign w_wr_done = (r_state == WR_THRU) && sram_ready;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ready     = 1'b1;
    read_data = '0;
    unique case (r_state)
      IDLE: begin
        if (mem_w_en)      ready = 1'b0;
        else if (mem_r_en) ready = w_hit;
        if (w_rd_hit) read_data = select_word(w_line[w_hit_way], w_fields.word_sel);
      end
      RD_MISS: begin
        ready = sram_ready;
        if (sram_ready) read_data = select_word(sram_read_data, w_fields.word_sel);
      end
      WR_THRU: ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sram_r_en <= 1'b0;
      r_sram_w_en <= 1'b0;
      r_lru       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            r_state     <= WR_THRU;
            r_sram_w_en <= 1'b1;
          end else if (mem_r_en) begin
            if (w_hit) begin
              r_lru[w_fields.index] <= ~w_hit_way;
            end else begin
              r_state     <= RD_MISS;
              r_sram_r_en <= 1'b1;
            end
          end
        end
        RD_MISS: if (sram_ready) begin
          r_lru[w_fields.index] <= ~r_lru[w_fields.index];
          r_state               <= IDLE;
          r_sram_r_en           <= 1'b0;
        end
        WR_THRU: if (sram_ready) begin
          r_state     <= IDLE;
          r_sram_w_en <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_rd_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_rd_done) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a transparent-memory + per-set LRU list model
// predicts hit/miss, latency and data; directed cases pin the model, then random traffic.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready, sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .ready           (ready),
    .sram_r_en       (sram_r_en),
    .sram_w_en       (sram_w_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory is the truth; the cache only decides timing.
  logic [31:0] mem [int unsigned];
  int unsigned set_tag [64][2];   // [s][0] = least recently used, [s][1] = most recent
  int          set_cnt [64];
  int          model_hits, model_misses;

  function automatic int unsigned eff_of(input logic [31:0] a);
    return (a & ~32'h3) - 32'd1024;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic int find(input int unsigned s, input int unsigned t);
    for (int i = 0; i < set_cnt[s]; i++) if (set_tag[s][i] == t) return i;
    return -1;
  endfunction

  function automatic void touch(input int unsigned s, input int unsigned t);
    int i;
    i = find(s, t);
    if (i == 0 && set_cnt[s] == 2) begin
      set_tag[s][0] = set_tag[s][1];
      set_tag[s][1] = t;
    end else if (i < 0) begin
      if (set_cnt[s] == 2) begin
        set_tag[s][0] = set_tag[s][1];
        set_tag[s][1] = t;
      end else begin
        set_tag[s][set_cnt[s]] = t;
        set_cnt[s]++;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) set_cnt[s] = 0;
    model_hits   = 0;
    model_misses = 0;
  endfunction

  // Per-cycle expectations consumed by the compare process at the falling edge.
  bit          exp_chk = 1'b0;
  logic        exp_ready, exp_ren, exp_wen;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    if (exp_chk) begin
      check("ready",           ready,           exp_ready);
      check("read_data",       read_data,       exp_rdata);
      check("sram_r_en",       sram_r_en,       exp_ren);
      check("sram_w_en",       sram_w_en,       exp_wen);
      check("sram_address",    sram_address,    address);
      check("sram_write_data", sram_write_data, write_data);
    end
  end

  task automatic set_exp(input logic rdy, input logic [31:0] rd, input logic ren, input logic wen);
    exp_chk   = 1'b1;
    exp_ready = rdy;
    exp_rdata = rd;
    exp_ren   = ren;
    exp_wen   = wen;
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    last_rdata = read_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle();
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    address    = 32'h400 + ($urandom_range(0, 255) << 2);
    sram_ready = 1'($urandom_range(0, 1));
    set_exp(1'b1, 32'h0, 1'b0, 1'b0);
    finish_cycle();
  endtask

  task automatic do_read(input logic [31:0] addr, input int lat, output bit was_hit);
    int unsigned e, w, s, t;
    logic [31:0] exp_d;
    e = eff_of(addr); w = e >> 2; s = (e >> 3) % 64; t = (e >> 9) % 1024;
    exp_d   = mem_rd(w);
    was_hit = (find(s, t) >= 0);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = addr; write_data = $urandom;
    sram_ready     = 1'($urandom_range(0, 1));
    sram_read_data = {$urandom, $urandom};
    if (was_hit) begin
      set_exp(1'b1, exp_d, 1'b0, 1'b0);
      finish_cycle();
      model_hits++;
    end else begin
      set_exp(1'b0, 32'h0, 1'b0, 1'b0);
      finish_cycle();
      for (int k = 0; k < lat; k++) begin
        sram_ready     = 1'b0;
        sram_read_data = {$urandom, $urandom};
        set_exp(1'b0, 32'h0, 1'b1, 1'b0);
        finish_cycle();
      end
      sram_ready     = 1'b1;
      sram_read_data = {mem_rd(w | 32'd1), mem_rd(w & ~32'd1)};
      set_exp(1'b1, exp_d, 1'b1, 1'b0);
      finish_cycle();
      model_misses++;
    end
    touch(s, t);
    mem_r_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat,
                          input logic also_read);
    int unsigned w;
    w = eff_of(addr) >> 2;
    mem_w_en = 1'b1; mem_r_en = also_read; address = addr; write_data = data;
    sram_ready     = 1'($urandom_range(0, 1));
    sram_read_data = {$urandom, $urandom};
    set_exp(1'b0, 32'h0, 1'b0, 1'b0);
    finish_cycle();
    for (int k = 0; k < lat; k++) begin
      sram_ready = 1'b0;
      set_exp(1'b0, 32'h0, 1'b0, 1'b1);
      finish_cycle();
    end
    sram_ready = 1'b1;
    set_exp(1'b1, 32'h0, 1'b0, 1'b1);
    finish_cycle();
    mem[w]   = data;
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'h400; write_data = '0;
    sram_ready = 1'b1; sram_read_data = '0;
    model_reset();
    mem[0] = 32'hAAAA1111;
    mem[1] = 32'hBBBB0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_idle();

    do_read(32'h400, 2, h);
    check("cold_400_hit", h, 0);
    check("cold_400_data", last_rdata, 32'hAAAA1111);
    do_read(32'h404, 0, h);
    check("hit_404_hit", h, 1);
    check("hit_404_data", last_rdata, 32'hBBBB0000);
    do_read(32'h600, 1, h);
    do_read(32'h400, 0, h);
    do_read(32'h800, 1, h);
    check("evict_800_hit", h, 0);
    do_read(32'h400, 0, h);
    check("reread_400_hit", h, 1);
    do_read(32'h600, 1, h);
    check("reread_600_hit", h, 0);

    do_write(32'h404, 32'h12345678, 2, 1'b0);
    do_read(32'h404, 0, h);
    check("wr_hit_404_hit", h, 1);
    check("wr_hit_404_data", last_rdata, 32'h12345678);
    do_write(32'h900, 32'hCAFEF00D, 1, 1'b1);
    do_read(32'h900, 1, h);
    check("noalloc_900_hit", h, 0);
    check("noalloc_900_data", last_rdata, 32'hCAFEF00D);
    do_idle();

    // Reset while a miss is outstanding.
    mem_r_en = 1'b1; address = 32'h1000; sram_ready = 1'b0;
    set_exp(1'b0, 32'h0, 1'b0, 1'b0);
    finish_cycle();
    set_exp(1'b0, 32'h0, 1'b1, 1'b0);
    finish_cycle();
    rst = 1'b1; mem_r_en = 1'b0;
    set_exp(1'b0, 32'h0, 1'b1, 1'b0);
    finish_cycle();
    rst = 1'b0;
    model_reset();
    do_idle();
    do_read(32'h400, 1, h);
    check("post_rst_400_hit", h, 0);
    do_read(32'h404, 0, h);
    do_read(32'h400, 0, h);
    do_read(32'hA00, 0, h);
    do_read(32'hA00, 0, h);
    check("stats_seq_last_hit", h, 1);
    do_idle();
`ifdef CACHE_STATS_EN
    check("hit_count_3", hit_count, 32'd3);
    check("miss_count_2", miss_count, 32'd2);
`endif
    rst = 1'b1;
    set_exp(1'b1, 32'h0, 1'b0, 1'b0);
    finish_cycle();
    rst = 1'b0;
    model_reset();
    do_idle();
`ifdef CACHE_STATS_EN
    check("hit_count_rst", hit_count, 32'd0);
    check("miss_count_rst", miss_count, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      int unsigned op, e;
      logic [31:0] a;
      e  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
      a  = e + 32'd1024 + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 99);
      if (op < 50)      do_read(a, $urandom_range(0, 3), h);
      else if (op < 80) do_write(a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else              do_idle();
    end
    do_idle();
`ifdef CACHE_STATS_EN
    check("hit_count_rand", hit_count, 32'(model_hits));
    check("miss_count_rand", miss_count, 32'(model_misses));
`endif

    exp_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
